// File: rtl/mod_pkg.sv
// Shared definitions for the modular-arithmetic datapath: default widths,
// the multiplier FSM encoding and the moduli of the supported schemes.
package mod_pkg;

    // Default widths: a full 23x23 product needs 46 bits; 48 leaves headroom
    // for the downstream reducer's input format.
    localparam int DEF_DATA_WIDTH = 48;
    localparam int DEF_Q_WIDTH    = 23;

    // Moduli of the lattice schemes this datapath serves.
    localparam int Q_KYBER     = 3329;
    localparam int Q_DILITHIUM = 8380417;
    localparam int Q_NTRU      = 4591;

    // Multiplier control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage : mod_pkg

// File: rtl/mod_operand_multiplier.sv
// Sequential shift-add multiplier feeding the modular reducer. Forms the full
// 2*Q_WIDTH-bit product of two residues over Q_WIDTH cycles, captures the
// modulus alongside the operands and flags operands that are not reduced.
module mod_operand_multiplier
    import mod_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int Q_WIDTH    = DEF_Q_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    input  logic [Q_WIDTH-1:0]    a,
    input  logic [Q_WIDTH-1:0]    b,
    input  logic [Q_WIDTH-1:0]    Q,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [Q_WIDTH-1:0]    q_out,
    output logic                  range_err
);

    localparam int PROD_WIDTH = 2 * Q_WIDTH;
    // One extra bit so the counter can represent Q_WIDTH-1 even for tiny widths.
    localparam int CNT_WIDTH  = $clog2(Q_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(Q_WIDTH - 1);

    // The product must fit the output word without truncation.
    generate
        if (DATA_WIDTH < 2 * Q_WIDTH) begin : g_width_check
            $error("mod_operand_multiplier: DATA_WIDTH must be >= 2*Q_WIDTH");
        end
    endgenerate

    mul_state_t state_reg;
    mul_state_t state_next;

    logic [PROD_WIDTH-1:0] acc_reg;
    logic [PROD_WIDTH-1:0] a_sh_reg;
    logic [Q_WIDTH-1:0]    b_sh_reg;
    logic [CNT_WIDTH-1:0]  cnt_reg;
    logic [Q_WIDTH-1:0]    q_cap_reg;
    logic                  err_cap_reg;

    logic [DATA_WIDTH-1:0] data_out_reg;
    logic [Q_WIDTH-1:0]    q_out_reg;
    logic                  range_err_reg;
    logic                  done_reg;

    logic                  accept;
    logic                  last_step;
    logic [PROD_WIDTH-1:0] acc_sum;

    // A new request is taken only when no product is in flight.
    assign accept    = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign last_step = (state_reg == ST_RUN) && (cnt_reg == CNT_LAST);

    // Partial-product accumulation for the current multiplier bit.
    assign acc_sum = acc_reg + (b_sh_reg[0] ? a_sh_reg : '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last bit,
    // DONE either restarts (back-to-back) or falls back to IDLE.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (start)     state_next = ST_RUN;
            ST_RUN:  if (last_step) state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add iteration and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg       <= '0;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            cnt_reg       <= '0;
            q_cap_reg     <= '0;
            err_cap_reg   <= 1'b0;
            data_out_reg  <= '0;
            q_out_reg     <= '0;
            range_err_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                acc_reg     <= '0;
                a_sh_reg    <= PROD_WIDTH'(a);
                b_sh_reg    <= b;
                cnt_reg     <= '0;
                q_cap_reg   <= Q;
                // Range status is decided on the raw captured operands;
                // Q = 0 makes every operand out of range.
                err_cap_reg <= (a >= Q) || (b >= Q);
            end else if (state_reg == ST_RUN) begin
                acc_reg  <= acc_sum;
                a_sh_reg <= a_sh_reg << 1;
                b_sh_reg <= b_sh_reg >> 1;
                cnt_reg  <= cnt_reg + 1'b1;
                // Outputs only move here, so they stay valid until the next done.
                if (last_step) begin
                    data_out_reg  <= DATA_WIDTH'(acc_sum);
                    q_out_reg     <= q_cap_reg;
                    range_err_reg <= err_cap_reg;
                    done_reg      <= 1'b1;
                end
            end
        end
    end

    assign busy      = (state_reg == ST_RUN);
    assign done      = done_reg;
    assign data_out  = data_out_reg;
    assign q_out     = q_out_reg;
    assign range_err = range_err_reg;

endmodule : mod_operand_multiplier

// File: tb/tb_mod_operand_multiplier.sv
// Scoreboard bench for mod_operand_multiplier: stimulus pushes hand-computed
// results, a negedge monitor pops and compares on every done pulse.
module tb_mod_operand_multiplier;

    localparam int DW = 48;
    localparam int QW = 23;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic [QW-1:0] a_in;
    logic [QW-1:0] b_in;
    logic [QW-1:0] q_in;
    logic          done;
    logic [DW-1:0] data_out;
    logic [QW-1:0] q_out;
    logic          range_err;

    mod_operand_multiplier #(
        .DATA_WIDTH(DW),
        .Q_WIDTH   (QW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .a        (a_in),
        .b        (b_in),
        .Q        (q_in),
        .done     (done),
        .data_out (data_out),
        .q_out    (q_out),
        .range_err(range_err)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [QW-1:0] q;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done with data_out %0d, required no done (cycle %0d)",
                         data_out, cyc);
            end else begin
                e = sb.pop_front();
                check("data_out", 64'(data_out), 64'(e.data));
                check("q_out", 64'(q_out), 64'(e.q));
                check("range_err", 64'(range_err), 64'(e.err));
                check("done_latency", 64'(cyc), 64'(e.cyc));
                check("busy_at_done", 64'(busy), 64'd0);
                $display("txn: cycle %0d data_out=%0d q_out=%0d range_err=%0d", cyc, data_out, q_out, range_err);
            end
        end
    end

    // Present a request for one cycle; optionally record its expected result.
    task automatic issue(input logic [QW-1:0] av, input logic [QW-1:0] bv, input logic [QW-1:0] qv,
                         input bit push, input logic [DW-1:0] exp_data, input logic exp_err);
        @(negedge clk);
        a_in  = av;
        b_in  = bv;
        q_in  = qv;
        start = 1'b1;
        if (push) sb.push_back('{data: exp_data, q: qv, err: exp_err, cyc: cyc + 24});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait until done is visible at a negedge.
    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done in 40 cycles, required done", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        int k;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        q_in  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_data_out", 64'(data_out), 64'd0);
        check("reset_q_out", 64'(q_out), 64'd0);
        check("reset_range_err", 64'(range_err), 64'd0);
        rst = 1'b0;

        // Kyber: busy must be high for exactly Q_WIDTH cycles.
        issue(23'd3328, 23'd3328, 23'd3329, 1'b1, 48'd11075584, 1'b0);
        busy_cnt = 0;
        k = 0;
        while (!done && k < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            k++;
        end
        check("kyber_busy_cycles", 64'(busy_cnt), 64'd23);

        // Dilithium maximal residues.
        issue(23'd8380416, 23'd8380416, 23'd8380417, 1'b1, 48'd70231372333056, 1'b0);
        wait_done("dilithium");

        // All-ones operands exceed Q.
        issue(23'd8388607, 23'd8388607, 23'd8380417, 1'b1, 48'd70368727400449, 1'b1);
        wait_done("extreme");

        // Zero multiplicand still takes the full latency.
        issue(23'd0, 23'd4590, 23'd4591, 1'b1, 48'd0, 1'b0);
        wait_done("zero_a");

        // Q = 0 flags range error but still computes the product.
        issue(23'd3, 23'd4, 23'd0, 1'b1, 48'd12, 1'b1);
        wait_done("q_zero");

        // Back-to-back: restart accepted in the done cycle.
        issue(23'd5, 23'd7, 23'd3329, 1'b1, 48'd35, 1'b0);
        wait_done("b2b_first");
        a_in  = 23'd2;
        b_in  = 23'd3;
        q_in  = 23'd3329;
        start = 1'b1;
        sb.push_back('{data: 48'd6, q: 23'd3329, err: 1'b0, cyc: cyc + 24});
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done("b2b_second");

        // Start pulse mid-RUN with different operands is ignored.
        issue(23'd100, 23'd200, 23'd3329, 1'b1, 48'd20000, 1'b0);
        repeat (5) @(negedge clk);
        a_in  = 23'd7;
        b_in  = 23'd9;
        q_in  = 23'd11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("mid_run_start");
        @(negedge clk);

        // Reset at cycle 10 of RUN discards the operation.
        issue(23'd1234, 23'd5678, 23'd8380417, 1'b0, '0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_data_out", 64'(data_out), 64'd0);
        check("midrst_q_out", 64'(q_out), 64'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        // Fresh operation after reset.
        issue(23'd10, 23'd20, 23'd3329, 1'b1, 48'd200, 1'b0);
        wait_done("post_reset");

        // Hold: inputs wander without start; outputs must not move.
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            a_in = 23'($urandom);
            b_in = 23'($urandom);
            q_in = 23'($urandom);
            if (i == 1 || i == 25 || i == 50) begin
                check("hold_data_out", 64'(data_out), 64'd200);
                check("hold_q_out", 64'(q_out), 64'd3329);
                check("hold_range_err", 64'(range_err), 64'd0);
            end
        end

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mod_operand_multiplier

// File: doc/mod_operand_multiplier.md
Name: mod_operand_multiplier

Overview:
Sequential shift-add multiplier directly upstream of modular_reduction. It forms the full product of two residues a, b < Q and presents it as a DATA_WIDTH-bit value. Its done pulse and data_out connect straight to the reducer's start and data_in. It also captures Q with the operands and flags operands that are not reduced.

Parameters:
DATA_WIDTH, 48, product/output width; must satisfy DATA_WIDTH >= 2*Q_WIDTH (elaboration-time check)
Q_WIDTH, 23, operand and modulus width; also the iteration count

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only in IDLE or DONE
busy  output  1  high while in RUN
a  input  Q_WIDTH  multiplicand, sampled on accepting edge
b  input  Q_WIDTH  multiplier, sampled on accepting edge
Q  input  Q_WIDTH  modulus, sampled on accepting edge
done  output  1  one-cycle pulse; product valid
data_out  output  DATA_WIDTH  zero-extended a*b, held until next done
q_out  output  Q_WIDTH  captured Q, held with data_out, feeds reducer Q
range_err  output  1  registered with done: a_cap >= Q_cap or b_cap >= Q_cap

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, data_out=0, q_out=0, range_err=0; counter, accumulator and operand registers cleared. Reset wins over every other event, including mid-RUN; the in-flight operation is discarded with no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start=1 at edge N, capture a, b, Q; acc=0; cnt=0; go to RUN.
  - RUN: busy=1. At each edge, if b_sh[0] then acc += a_sh. Then a_sh <<= 1, b_sh >>= 1, cnt++. acc and a_sh are 2*Q_WIDTH bits wide, with no truncation.
  - RUN exit: on the edge where cnt reaches Q_WIDTH-1 (edge N+Q_WIDTH), load data_out = zero-extended final acc and load q_out and range_err, then go to DONE.
  - DONE: done=1 for exactly this one cycle; busy=0. If start=1 at this edge, capture new operands and go to RUN (back-to-back). Otherwise go to IDLE.
- Latency: done is high in the cycle after edge N+Q_WIDTH, so it is sampled high at edge N+Q_WIDTH+1. Throughput is one product per Q_WIDTH+1 cycles.
- start while in RUN is ignored; no queuing, and captured operands are unaffected.
- data_out, q_out and range_err change only on the edge entering DONE, or on reset. They stay stable through IDLE, so the downstream block may sample them on done or later.
- range_err is informational. The product is still computed and done still pulses. Q=0 gives range_err=1.
- No early termination: b=0 still takes the full latency.

Decomposition:
- Shared package (mod_pkg): DATA_WIDTH/Q_WIDTH defaults, FSM state enum (IDLE/RUN/DONE), Kyber/Dilithium/NTRU modulus constants (3329, 8380417, 4591).
- No sub-module needed. Optional mod_mul_reduce_top instantiates this block plus modular_reduction (done->start, data_out->data_in, q_out->Q); it is not part of this block.

Test Plan:
- Kyber: Q=3329, a=3328, b=3328, start one cycle -> done at edge N+24, data_out=11075584, range_err=0, q_out=3329; busy high for 23 cycles.
- Dilithium: Q=8380417, a=b=8380416 -> data_out=70231372333056, range_err=0.
- Extremes: Q=8380417, a=b=8388607 -> data_out=70368727400449, range_err=1. Then a=0, b=4590, Q=4591 -> data_out=0, range_err=0, full latency.
- Back-to-back: start held high through the done cycle with new a=2, b=3, Q=3329 -> second done exactly 24 cycles after the first, data_out=6. A start pulse mid-RUN -> ignored, result unchanged.
- Reset mid-op: rst=1 at cycle 10 of RUN -> next cycle busy=0, done=0, data_out=0; no done pulse follows. A fresh start then completes normally.
- Hold: after done, change a/b/Q without start for 50 cycles -> data_out, q_out and range_err unchanged.
